// File: rtl/nco_sincos.sv
// Quadrature NCO: 32-bit phase accumulator with a quarter-wave sine table
// feeding a 3-stage pipeline to signed sin/cos samples.
module nco_sincos #(
  parameter int PHASE_W = 32,
  parameter int ANGLE_W = 12,
  parameter int MAG_W   = 13
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clken,
  input  logic [PHASE_W-1:0]       phi_inc_i,
  output logic signed [MAG_W-1:0]  fsin_o,
  output logic signed [MAG_W-1:0]  fcos_o,
  output logic                     out_valid
);

  localparam int IDX_W  = ANGLE_W - 2;
  localparam int ADDR_W = IDX_W + 1;
  localparam int QLEN   = 1 << IDX_W;
  localparam int ROM_W  = MAG_W - 1;

  // round(AMP * sin(pi*idx/(2*QLEN))) by fixed-point Taylor series (2^-60 scale),
  // evaluated at elaboration so the table needs no external init file.
  function automatic logic [ROM_W-1:0] qrom_val(input int idx);
    logic [127:0] x, x2, term, sum, amp;
    x    = (128'h3243F6A8885A308D * 128'(idx)) >> (IDX_W + 1);
    x2   = (x * x) >> 60;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    amp = sum * 128'((1 << ROM_W) - 1);
    amp = (amp + (128'd1 << 59)) >> 60;
    return ROM_W'(amp);
  endfunction

  function automatic logic [ADDR_W-1:0] fold(input logic [ANGLE_W-1:0] ang);
    logic [ADDR_W-1:0] idx;
    idx = {1'b0, ang[IDX_W-1:0]};
    return ang[IDX_W] ? ADDR_W'(QLEN) - idx : idx;
  endfunction

  logic [ROM_W-1:0] w_qrom [QLEN+1];

  for (genvar g = 0; g <= QLEN; g++) begin : g_qrom
    localparam logic [ROM_W-1:0] QV = qrom_val(g);
    assign w_qrom[g] = QV;
  end

  logic [PHASE_W-1:0]      r_acc;
  logic [ADDR_W-1:0]       r_sin_addr, r_cos_addr;
  logic [1:0]              r_s1_neg, r_s2_neg;
  logic [ROM_W-1:0]        r_sin_mag, r_cos_mag;
  logic signed [MAG_W-1:0] r_sin_out, r_cos_out;
  logic [1:0]              r_fill;

  logic [ANGLE_W-1:0]      w_sin_ang, w_cos_ang;
  logic [MAG_W-1:0]        w_sin_ext, w_cos_ext;

  assign w_sin_ang = r_acc[PHASE_W-1 -: ANGLE_W];
  assign w_cos_ang = w_sin_ang + ANGLE_W'(QLEN);
  assign w_sin_ext = {1'b0, r_sin_mag};
  assign w_cos_ext = {1'b0, r_cos_mag};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc      <= '0;
      r_sin_addr <= '0;
      r_cos_addr <= '0;
      r_s1_neg   <= '0;
      r_s2_neg   <= '0;
      r_sin_mag  <= '0;
      r_cos_mag  <= '0;
      r_sin_out  <= '0;
      r_cos_out  <= '0;
      r_fill     <= '0;
    end else if (clken) begin
      r_acc      <= r_acc + phi_inc_i;
      r_sin_addr <= fold(w_sin_ang);
      r_cos_addr <= fold(w_cos_ang);
      r_s1_neg   <= {w_sin_ang[ANGLE_W-1], w_cos_ang[ANGLE_W-1]};
      r_sin_mag  <= w_qrom[r_sin_addr];
      r_cos_mag  <= w_qrom[r_cos_addr];
      r_s2_neg   <= r_s1_neg;
      r_sin_out  <= r_s2_neg[1] ? -w_sin_ext : w_sin_ext;
      r_cos_out  <= r_s2_neg[0] ? -w_cos_ext : w_cos_ext;
      // Saturates once the pipeline is full; only reset clears it.
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  assign fsin_o    = r_sin_out;
  assign fcos_o    = r_cos_out;
  assign out_valid = (r_fill == 2'd3);

endmodule

// File: tb/tb_nco_sincos.sv
// Bench for nco_sincos: directed spot values plus randomized enable/increment/reset
// traffic, all checked against a trigonometric reference model.
module tb_nco_sincos;

  localparam real PI = 3.14159265358979323846;

  logic               clk;
  logic               reset_n;
  logic               clken;
  logic [31:0]        phi_inc_i;
  logic signed [12:0] fsin_o;
  logic signed [12:0] fcos_o;
  logic               out_valid;

  nco_sincos dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .phi_inc_i (phi_inc_i),
    .fsin_o    (fsin_o),
    .fcos_o    (fcos_o),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference model: sample k is the waveform at phase k*inc, shown 3 enabled edges later.
  bit [31:0] m_acc;
  bit [31:0] m_hist[$];
  int        m_sin, m_cos, m_valid, m_idx;

  function automatic int ref_amp(input int ang);
    real v;
    v = 4095.0 * $sin(2.0 * PI * ang / 4096.0);
    if (v >= 0.0) return int'($floor(v + 0.5));
    else          return -int'($floor(-v + 0.5));
  endfunction

  task automatic model_edge();
    bit [31:0] ph;
    int        theta;
    if (!reset_n) begin
      m_acc = 0;
      m_hist.delete();
      m_sin = 0; m_cos = 0; m_valid = 0; m_idx = -1;
    end else if (clken) begin
      m_hist.push_back(m_acc);
      m_acc = m_acc + phi_inc_i;
      if (m_hist.size() > 3) void'(m_hist.pop_front());
      if (m_hist.size() == 3) begin
        ph      = m_hist[0];
        theta   = int'(ph >> 20);
        m_sin   = ref_amp(theta);
        m_cos   = ref_amp((theta + 1024) % 4096);
        m_valid = 1;
        m_idx++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("valid", int'(out_valid), m_valid);
    chk("sin", int'(fsin_o), m_sin);
    chk("cos", int'(fcos_o), m_cos);
  endtask

  task automatic run_to_sample(input int k, input string tag);
    int guard = 0;
    while (m_idx != k && guard < 1000) begin
      tick();
      guard++;
    end
    if (m_idx != k) chk({tag, "_timeout"}, m_idx, k);
  endtask

  int qsin[4] = '{0, 4095, 0, -4095};
  int qcos[4] = '{4095, 0, -4095, 0};

  initial begin
    reset_n   = 1'b0;
    clken     = 1'b1;
    phi_inc_i = 32'h028F5C29;
    m_acc = 0; m_sin = 0; m_cos = 0; m_valid = 0; m_idx = -1;

    repeat (7) begin
      tick();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_sin", int'(fsin_o), 0);
      chk("rst_cos", int'(fcos_o), 0);
    end

    reset_n = 1'b1;
    tick(); tick();
    chk("fill_lat", int'(out_valid), 0);
    tick();
    chk("first_valid", int'(out_valid), 1);
    chk("s0_sin", int'(fsin_o), 0);
    chk("s0_cos", int'(fcos_o), 4095);

    run_to_sample(1, "s1");
    chk("s1_sin", int'(fsin_o), 251);
    chk("s1_cos", int'(fcos_o), 4087);
    run_to_sample(25, "s25");
    chk("s25_sin", int'(fsin_o), 4095);
    chk("s25_cos", int'(fcos_o), 0);
    run_to_sample(50, "s50");
    chk("s50_sin", int'(fsin_o), 0);
    chk("s50_cos", int'(fcos_o), -4095);

    run_to_sample(60, "s60");
    clken = 1'b0;
    repeat (5) begin
      tick();
      chk("gate_valid", int'(out_valid), 1);
    end
    clken = 1'b1;
    run_to_sample(100, "s100");
    chk("s100_sin", int'(fsin_o), 0);
    chk("s100_cos", int'(fcos_o), 4095);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    run_to_sample(37, "s37");
    reset_n = 1'b0;
    tick();
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_sin", int'(fsin_o), 0);
    reset_n = 1'b1;
    tick(); tick();
    chk("restart_lat", int'(out_valid), 0);
    tick();
    chk("restart_valid", int'(out_valid), 1);
    chk("restart_sin", int'(fsin_o), 0);
    chk("restart_cos", int'(fcos_o), 4095);

    reset_n = 1'b0;
    tick();
    phi_inc_i = 32'h40000000;
    reset_n   = 1'b1;
    run_to_sample(0, "quad0");
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      chk("quad_sin", int'(fsin_o), qsin[k % 4]);
      chk("quad_cos", int'(fcos_o), qcos[k % 4]);
    end

    for (int c = 0; c < 600; c++) begin
      clken = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 40) == 0) phi_inc_i = $urandom;
      reset_n = ($urandom_range(0, 150) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
